// File: rtl/rx_data_store_pkg.sv
// rx_data_store_pkg: shared FSM encoding and default widths for the rx/tx buffer sequencers
package rx_data_store_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 16;
endpackage

// File: rtl/rx_data_store.sv
// rx_data_store: captures received UART bytes into an external RAM until the buffer is full
module rx_data_store
  import rx_data_store_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_done,
  input  logic [DATA_W-1:0] rx_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              fin,
  output logic              overrun
);
  state_t state, state_nx;
  logic [ADDR_W-1:0] cnt;
  logic last, accept, arm;
  assign last = &cnt;
  assign busy = state == RECV;
  // next state: start arms a run outside RECV; the byte landing on the top address ends it
  always_comb begin
    state_nx = state;
    accept = 1'b0;
    arm = 1'b0;
    if (state == RECV) begin
      accept = rx_done;
      state_nx = rx_done && last ? DONE : RECV;
    end else if (start) begin
      arm = 1'b1;
      state_nx = RECV;
    end
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // write port, address counter and status flags; counter saturates at the top address
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      fin <= 1'b0;
      overrun <= 1'b0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr <= cnt;
        wr_data <= rx_data;
      end
      cnt <= arm ? '0 : accept && !last ? cnt + 1'b1 : cnt;
      fin <= arm ? 1'b0 : accept && last ? 1'b1 : fin;
      overrun <= arm ? 1'b0 : state == DONE && rx_done ? 1'b1 : overrun;
    end
endmodule

// File: tb/tb_rx_data_store.sv
// tb_rx_data_store: randomized and directed checks of rx_data_store against a behavioural buffer model
module tb_rx_data_store;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AW;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic rx_done = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic wr_en, busy, fin, overrun;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  int checks = 0;
  int errors = 0;
  bit capturing, full, ovr, exp_wr;
  int count, last_addr, last_data;
  bit prev_rx;

  rx_data_store #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_done(rx_done), .rx_data(rx_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .fin(fin), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("wr_en", 32'(wr_en), 32'(exp_wr));
    chk("wr_addr", 32'(wr_addr), 32'(last_addr));
    chk("wr_data", 32'(wr_data), 32'(last_data));
    chk("busy", 32'(busy), 32'(capturing));
    chk("fin", 32'(fin), 32'(full));
    chk("overrun", 32'(overrun), 32'(ovr));
  endtask

  task automatic model_reset();
    capturing = 0; full = 0; ovr = 0; exp_wr = 0;
    count = 0; last_addr = 0; last_data = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    rx_done = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    prev_rx = 0;
    check_all();
  endtask

  task automatic step(input bit s, input bit r, input logic [DW-1:0] d);
    start = s;
    rx_done = r;
    rx_data = d;
    @(posedge clk);
    exp_wr = 0;
    if (!capturing) begin
      if (s) begin
        capturing = 1; count = 0; full = 0; ovr = 0;
      end else if (r && full) ovr = 1;
    end else if (r) begin
      exp_wr = 1;
      last_addr = count;
      last_data = int'(d);
      count++;
      if (count == DEPTH) begin
        capturing = 0;
        full = 1;
      end
    end
    prev_rx = r;
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    prev_rx = 0;
    rst = 1'b1;
    #12;
    check_all();
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(0, 1, 8'h55);
    step(0, 0, 8'h00);
    step(1, 0, 8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 8'(8'h10 + i));
      step(0, 0, 8'h00);
      step(0, 0, 8'h00);
    end
    step(0, 1, 8'hAA);
    step(0, 0, 8'h00);
    step(1, 0, 8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 8'(i * 7));
      step(0, 0, 8'h00);
    end
    step(1, 1, 8'h77);
    step(0, 0, 8'h00);
    step(0, 1, 8'h01);
    step(0, 0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 8'(8'h40 + i));
      step(0, 0, 8'h00);
    end
    do_reset();
    step(0, 1, 8'h33);
    step(1, 0, 8'h00);
    step(0, 1, 8'h99);
    step(0, 0, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else begin
        bit s, r;
        s = $urandom_range(0, 39) == 0;
        r = !prev_rx && $urandom_range(0, 2) == 0;
        step(s, r, 8'($urandom));
      end
    end
    do_reset();
    step(1, 0, 8'h00);
    for (int i = 0; i < DEPTH + 2; i++) begin
      step(0, 1, 8'($urandom));
      step(0, 0, 8'h00);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
